// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default widths and the
// arbiter state encoding (also the value driven on mode_o).
package dmem_pkg;

    localparam int DMEM_ADDR_W = 14;
    localparam int DMEM_DATA_W = 32;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_PROG    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // The CPU is held off in every state except RUN.
    function automatic logic cpu_blocked(input logic [1:0] st);
        return (st != ST_RUN);
    endfunction

endpackage

// File: rtl/dmem_arbiter_upg_hold_buf.sv
// One-entry hold register for UART program writes. A load while the entry is
// occupied and not being drained in the same cycle keeps the older entry
// (write order is preserved) and sets a sticky overflow flag.
module upg_hold_buf #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [DATA_W-1:0] dat_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [DATA_W-1:0] dat_o,
    output logic              ovf_o
);

    logic              valid_q;
    logic              ovf_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] dat_q;

    // Entry bookkeeping: capture on load, free on drain, flag lost writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
        end else if (load_i && valid_q && !drain_i) begin
            ovf_q   <= 1'b1;
        end else if (load_i) begin
            valid_q <= 1'b1;
            adr_q   <= adr_i;
            dat_q   <= dat_i;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign adr_o   = adr_q;
    assign dat_o   = dat_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port RAM between the CPU (RUN) and
// the UART program loader (PROG), with one-cycle DRAIN/RELEASE guard states.
// RAM-side outputs are combinational so a CPU access costs no extra latency;
// they are forced idle while rst_i is high so no write can escape a reset.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_wen_i,
    input  logic [ADDR_W-1:0] cpu_adr_i,
    input  logic [DATA_W-1:0] cpu_dat_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_dat_o,
    output logic              cpu_stall_o,
    input  logic              upg_wen_i,
    input  logic [ADDR_W-1:0] upg_adr_i,
    input  logic [DATA_W-1:0] upg_dat_i,
    input  logic              upg_done_i,
    output logic              ram_en_o,
    output logic              ram_wen_o,
    output logic [ADDR_W-1:0] ram_adr_o,
    output logic [DATA_W-1:0] ram_wdat_o,
    input  logic [DATA_W-1:0] ram_rdat_i,
    output logic [1:0]        mode_o
);

    logic [1:0]        state_q, state_d;
    logic              ack_q;
    logic              ld_q;
    logic [DATA_W-1:0] dat_q;

    logic              cpu_go_s;
    logic              upg_entry_s;
    logic              hold_load_s;
    logic              hold_drain_s;
    logic              hold_vld_s;
    logic [ADDR_W-1:0] hold_adr_s;
    logic [DATA_W-1:0] hold_dat_s;
    logic              dbg_ovf_unused_s;

    assign cpu_go_s     = (state_q == ST_RUN) && cpu_req_i && !rst_i;
    assign upg_entry_s  = (state_q == ST_RUN) && upg_wen_i && !upg_done_i && !rst_i;
    // Pulses that cannot go straight to the RAM are parked: the entry pulse,
    // pulses during DRAIN, and pulses in PROG while the hold slot is busy.
    assign hold_load_s  = upg_entry_s ||
                          (!rst_i && upg_wen_i &&
                           ((state_q == ST_DRAIN) || ((state_q == ST_PROG) && hold_vld_s)));
    assign hold_drain_s = (state_q == ST_PROG) && hold_vld_s && !rst_i;

    upg_hold_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (hold_load_s),
        .drain_i (hold_drain_s),
        .adr_i   (upg_adr_i),
        .dat_i   (upg_dat_i),
        .valid_o (hold_vld_s),
        .adr_o   (hold_adr_s),
        .dat_o   (hold_dat_s),
        .ovf_o   (dbg_ovf_unused_s)
    );

    // Next-state logic for RUN -> DRAIN -> PROG -> RELEASE -> RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (upg_entry_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_PROG;
            end
            ST_PROG: begin
                if (upg_done_i && !upg_wen_i && !hold_vld_s) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_PROG;
                end
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // RAM port mux: CPU in RUN, held entry first then live pulses in PROG.
    always_comb begin
        ram_en_o   = 1'b0;
        ram_wen_o  = 1'b0;
        ram_adr_o  = cpu_adr_i;
        ram_wdat_o = cpu_dat_i;
        if (cpu_go_s) begin
            ram_en_o  = 1'b1;
            ram_wen_o = cpu_wen_i;
        end else if ((state_q == ST_PROG) && !rst_i) begin
            if (hold_vld_s) begin
                ram_en_o   = 1'b1;
                ram_wen_o  = 1'b1;
                ram_adr_o  = hold_adr_s;
                ram_wdat_o = hold_dat_s;
            end else if (upg_wen_i) begin
                ram_en_o   = 1'b1;
                ram_wen_o  = 1'b1;
                ram_adr_o  = upg_adr_i;
                ram_wdat_o = upg_dat_i;
            end else begin
                ram_en_o   = 1'b0;
            end
        end else begin
            ram_en_o = 1'b0;
        end
    end

    // State, CPU ack and load-data holding register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            ack_q   <= 1'b0;
            ld_q    <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= cpu_go_s;
            ld_q    <= cpu_go_s && !cpu_wen_i;
            if (ld_q) begin
                dat_q <= ram_rdat_i;
            end
        end
    end

    // Read data arrives from the RAM in the ack cycle; afterwards the copy
    // in dat_q keeps it stable until the next load completes.
    assign cpu_dat_o   = ld_q ? ram_rdat_i : dat_q;
    assign cpu_ack_o   = ack_q;
    assign cpu_stall_o = cpu_blocked(state_q);
    assign mode_o      = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_wen;
    logic [13:0] cpu_adr;
    logic [31:0] cpu_dat;
    logic        cpu_ack;
    logic [31:0] cpu_rdat;
    logic        cpu_stall;
    logic        upg_wen, upg_done;
    logic [13:0] upg_adr;
    logic [31:0] upg_dat;
    logic        ram_en, ram_wen;
    logic [13:0] ram_adr;
    logic [31:0] ram_wdat;
    logic [31:0] ram_rdat;
    logic [1:0]  mode;

    logic [31:0] mem [0:16383];
    int          wr201_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(14), .DATA_W(32)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_wen_i(cpu_wen), .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat),
        .cpu_ack_o(cpu_ack), .cpu_dat_o(cpu_rdat), .cpu_stall_o(cpu_stall),
        .upg_wen_i(upg_wen), .upg_adr_i(upg_adr), .upg_dat_i(upg_dat), .upg_done_i(upg_done),
        .ram_en_o(ram_en), .ram_wen_o(ram_wen), .ram_adr_o(ram_adr), .ram_wdat_o(ram_wdat),
        .ram_rdat_i(ram_rdat), .mode_o(mode)
    );

    // RAM model, same clock edge as the arbiter.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen) mem[ram_adr] <= ram_wdat;
            else         ram_rdat <= mem[ram_adr];
        end
        if (ram_en && ram_wen && ram_adr == 14'h0201) wr201_cnt <= wr201_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_wen = 1'b0; cpu_adr = 14'd0; cpu_dat = 32'd0;
        upg_wen = 1'b1; upg_done = 1'b0; upg_adr = 14'd7; upg_dat = 32'd7;
        tick(); tick();
        // reset state; UART pulse during reset must be ignored
        rst = 1'b0; upg_wen = 1'b0; upg_done = 1'b1;
        #1;
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_dat", cpu_rdat, 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);

        // store then load 0x0010
        cpu_req = 1'b1; cpu_wen = 1'b1; cpu_adr = 14'h0010; cpu_dat = 32'hDEAD_BEEF;
        #1;
        chk("st_en", 32'(ram_en), 32'd1);
        chk("st_wen", 32'(ram_wen), 32'd1);
        chk("st_adr", 32'(ram_adr), 32'h10);
        chk("st_wdat", ram_wdat, 32'hDEAD_BEEF);
        chk("st_ack0", 32'(cpu_ack), 32'd0);
        tick();
        cpu_wen = 1'b0;
        #1;
        chk("st_ack", 32'(cpu_ack), 32'd1);
        chk("ld_wen", 32'(ram_wen), 32'd0);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("ld_ack", 32'(cpu_ack), 32'd1);
        chk("ld_dat", cpu_rdat, 32'hDEAD_BEEF);
        chk("idle_en", 32'(ram_en), 32'd0);
        tick();
        chk("ack_pulse", 32'(cpu_ack), 32'd0);
        chk("dat_hold", cpu_rdat, 32'hDEAD_BEEF);

        // preload adr 0..2 back-to-back stores
        for (int i = 0; i < 3; i++) begin
            cpu_req = 1'b1; cpu_wen = 1'b1; cpu_adr = 14'(i); cpu_dat = pat(i);
            #1;
            chk("pre_en", 32'(ram_en), 32'd1);
            if (i > 0) chk("pre_ack", 32'(cpu_ack), 32'd1);
            tick();
        end
        chk("dat_hold_st", cpu_rdat, 32'hDEAD_BEEF);

        // three back-to-back loads
        for (int i = 0; i < 3; i++) begin
            cpu_req = 1'b1; cpu_wen = 1'b0; cpu_adr = 14'(i);
            #1;
            chk("b2b_en", 32'(ram_en), 32'd1);
            chk("b2b_stall", 32'(cpu_stall), 32'd0);
            if (i > 0) begin
                chk("b2b_ack", 32'(cpu_ack), 32'd1);
                chk("b2b_dat", cpu_rdat, pat(i - 1));
            end
            tick();
        end
        cpu_req = 1'b0;
        #1;
        chk("b2b_ack_last", 32'(cpu_ack), 32'd1);
        chk("b2b_dat_last", cpu_rdat, pat(2));
        chk("b2b_en_off", 32'(ram_en), 32'd0);
        tick();

        // pulse with upg_done=1 in RUN is ignored
        upg_wen = 1'b1; upg_done = 1'b1; upg_adr = 14'h0055; upg_dat = 32'h5555_5555;
        #1;
        chk("ign_en", 32'(ram_en), 32'd0);
        tick();
        upg_wen = 1'b0;
        #1;
        chk("ign_mode", 32'(mode), 32'd0);
        chk("ign_stall", 32'(cpu_stall), 32'd0);
        tick();

        // UART entry with concurrent CPU load
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_adr = 14'd1;
        upg_wen = 1'b1; upg_done = 1'b0; upg_adr = 14'h3FFF; upg_dat = 32'h1234_5678;
        #1;
        chk("ent_mode", 32'(mode), 32'd0);
        chk("ent_en", 32'(ram_en), 32'd1);
        chk("ent_adr", 32'(ram_adr), 32'd1);
        tick();
        upg_wen = 1'b0; cpu_adr = 14'd5;
        #1;
        chk("drn_mode", 32'(mode), 32'd1);
        chk("drn_ack", 32'(cpu_ack), 32'd1);
        chk("drn_dat", cpu_rdat, pat(1));
        chk("drn_stall", 32'(cpu_stall), 32'd1);
        chk("drn_en", 32'(ram_en), 32'd0);
        tick();
        #1;
        chk("prg_mode", 32'(mode), 32'd2);
        chk("prg_en", 32'(ram_en), 32'd1);
        chk("prg_wen", 32'(ram_wen), 32'd1);
        chk("prg_adr", 32'(ram_adr), 32'h3FFF);
        chk("prg_wdat", ram_wdat, 32'h1234_5678);
        chk("prg_ack", 32'(cpu_ack), 32'd0);
        chk("prg_stall", 32'(cpu_stall), 32'd1);
        tick();

        // four UART writes two cycles apart
        for (int k = 0; k < 4; k++) begin
            upg_wen = 1'b1; upg_adr = 14'h0100 + 14'(k); upg_dat = 32'hC0DE_0000 + 32'(k);
            #1;
            chk("pw_en", 32'(ram_en), 32'd1);
            chk("pw_adr", 32'(ram_adr), 32'h0100 + 32'(k));
            chk("pw_wdat", ram_wdat, 32'hC0DE_0000 + 32'(k));
            chk("pw_ack", 32'(cpu_ack), 32'd0);
            tick();
            upg_wen = 1'b0;
            #1;
            chk("pw_gap_en", 32'(ram_en), 32'd0);
            chk("pw_mode", 32'(mode), 32'd2);
            tick();
        end
        upg_done = 1'b1; cpu_req = 1'b0;
        #1;
        chk("done_mode", 32'(mode), 32'd2);
        tick();
        chk("rel_mode", 32'(mode), 32'd3);
        chk("rel_en", 32'(ram_en), 32'd0);
        chk("rel_stall", 32'(cpu_stall), 32'd1);
        tick();
        chk("run_mode", 32'(mode), 32'd0);
        chk("run_stall", 32'(cpu_stall), 32'd0);
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_adr = 14'h0103;
        #1;
        chk("run_en", 32'(ram_en), 32'd1);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("last_ack", 32'(cpu_ack), 32'd1);
        chk("last_dat", cpu_rdat, 32'hC0DE_0003);
        tick();

        // reset mid-PROG with a pending hold entry
        upg_done = 1'b0; upg_wen = 1'b1; upg_adr = 14'h0200; upg_dat = 32'hAAAA_5555;
        tick();
        upg_wen = 1'b0;
        #1;
        chk("r_drn_mode", 32'(mode), 32'd1);
        tick();
        upg_wen = 1'b1; upg_adr = 14'h0201; upg_dat = 32'hBBBB_6666;
        #1;
        chk("r_prg_adr", 32'(ram_adr), 32'h0200);
        chk("r_prg_wdat", ram_wdat, 32'hAAAA_5555);
        tick();
        upg_wen = 1'b0; rst = 1'b1;
        #1;
        chk("r_rst_en", 32'(ram_en), 32'd0);
        tick();
        rst = 1'b0; upg_done = 1'b1;
        #1;
        chk("r_mode", 32'(mode), 32'd0);
        chk("r_ack", 32'(cpu_ack), 32'd0);
        chk("r_dat", cpu_rdat, 32'd0);
        chk("r_stall", 32'(cpu_stall), 32'd0);
        chk("r_en", 32'(ram_en), 32'd0);
        chk("r_no_wr201", 32'(wr201_cnt), 32'd0);
        tick();
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_adr = 14'h0200;
        tick();
        cpu_adr = 14'h3FFF;
        #1;
        chk("r_ld200_ack", 32'(cpu_ack), 32'd1);
        chk("r_ld200_dat", cpu_rdat, 32'hAAAA_5555);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("r_ld3fff_dat", cpu_rdat, 32'h1234_5678);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
